rf_wb_arb: RTL and testbench

//  Shares the single write port of the 8x8 register file (reg_ff) between two writeback

---
 rtl/octa_rf_pkg.sv | 20 ++
 rtl/reg_ff.sv | 37 +++
 rtl/rf_wb_arb_rr_arb2.sv | 45 ++++
 rtl/rf_wb_arb.sv | 106 ++++++++++
 tb/tb_rf_wb_arb.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/octa_rf_pkg.sv
// Shared sizing, types and grant encoding for the register-file writeback arbiter.
//   DW    : register data width
//   AW    : register address width
//   NREGS : number of registers (2**AW)
package octa_rf_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned NREGS = 2 ** AW;

  typedef logic [AW-1:0] rf_addr_t;
  typedef logic [DW-1:0] rf_data_t;

  // Identity of the requester that won the most recent handshake.
  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

endpackage : octa_rf_pkg

// File: rtl/reg_ff.sv
// 2**AW x DW register file: one synchronous write port, two combinational read ports.
// Ports:
//   clk          : clock (storage has no reset; contents survive rst_n)
//   wr_en/rd/din : write port, committed on the rising edge when wr_en=1
//   rs1/rs2      : read addresses
//   r1/r2        : read data
module reg_ff
  import octa_rf_pkg::*;
#(
  parameter int unsigned P_DW = DW,
  parameter int unsigned P_AW = AW
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [P_AW-1:0] rd,
  input  logic [P_DW-1:0] din,
  input  logic [P_AW-1:0] rs1,
  input  logic [P_AW-1:0] rs2,
  output logic [P_DW-1:0] r1,
  output logic [P_DW-1:0] r2
);

  localparam int unsigned LP_N = 2 ** P_AW;

  logic [P_DW-1:0] r_mem [LP_N];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[rd] <= din;
    end
  end

  assign r1 = r_mem[rs1];
  assign r2 = r_mem[rs2];

endmodule : reg_ff

// File: rtl/rf_wb_arb_rr_arb2.sv
// Two-way round-robin arbiter with a remembered last winner.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_req[1:0] : request vector, bit 0 = A, bit 1 = B
//   o_gnt[1:0] : one-hot grant (combinational), never set without the matching request
// Reset leaves last winner at B so A takes the first tie.
module rr_arb2
  import octa_rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  grant_e r_last;
  grant_e w_last_nxt;

  // Last-winner register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= GNT_B;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  // Grant selection; every grant is a handshake, so the winner becomes last.
  always_comb begin
    o_gnt      = 2'b00;
    w_last_nxt = r_last;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == GNT_B) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
    if (o_gnt[0]) begin
      w_last_nxt = GNT_A;
    end else if (o_gnt[1]) begin
      w_last_nxt = GNT_B;
    end
  end

endmodule : rr_arb2

// File: rtl/rf_wb_arb.sv
// Writeback arbiter for the single register-file write port.
// Requesters A (ALU) and B (LSU) share the port through a round-robin arbiter;
// the winner is captured into one write stage that drives reg_ff the next cycle.
// Decode read addresses pass straight through; a read that hits the address in
// the write stage is a hazard.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   a_valid/a_ready/a_rd/a_data         : requester A handshake + payload
//   b_valid/b_ready/b_rd/b_data         : requester B handshake + payload
//   rs1, rs2 / r1, r2                   : decode read addresses / read data
//   stall                               : decode must hold rs1/rs2 and retry
//   rf_wr_en, rf_rd, rf_din             : registered write port to reg_ff
//   rf_rs1, rf_rs2 / rf_r1, rf_r2       : read port to/from reg_ff
// Build option: define RF_WB_BYPASS_EN to forward the write-stage data to a
// matching read port instead of stalling.
module rf_wb_arb
  import octa_rf_pkg::*;
#(
  parameter int unsigned P_DW = DW,
  parameter int unsigned P_AW = AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [P_AW-1:0] a_rd,
  input  logic [P_DW-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [P_AW-1:0] b_rd,
  input  logic [P_DW-1:0] b_data,
  input  logic [P_AW-1:0] rs1,
  input  logic [P_AW-1:0] rs2,
  output logic [P_DW-1:0] r1,
  output logic [P_DW-1:0] r2,
  output logic            stall,
  output logic            rf_wr_en,
  output logic [P_AW-1:0] rf_rd,
  output logic [P_DW-1:0] rf_din,
  output logic [P_AW-1:0] rf_rs1,
  output logic [P_AW-1:0] rf_rs2,
  input  logic [P_DW-1:0] rf_r1,
  input  logic [P_DW-1:0] rf_r2
);

  logic [1:0]      w_req;
  logic [1:0]      w_gnt;
  logic            w_hit1;
  logic            w_hit2;
  logic            r_wr_en;
  logic [P_AW-1:0] r_rd;
  logic [P_DW-1:0] r_din;

  assign w_req = {b_valid, a_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  // Grant is only given to a valid requester, so ready never rises without valid.
  assign a_ready = w_gnt[0];
  assign b_ready = w_gnt[1];

  // Write stage: always drains; a bubble leaves address/data holding old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_rd    <= '0;
      r_din   <= '0;
    end else begin
      r_wr_en <= |w_gnt;
      if (w_gnt[0]) begin
        r_rd  <= a_rd;
        r_din <= a_data;
      end else if (w_gnt[1]) begin
        r_rd  <= b_rd;
        r_din <= b_data;
      end
    end
  end

  assign rf_wr_en = r_wr_en;
  assign rf_rd    = r_rd;
  assign rf_din   = r_din;
  assign rf_rs1   = rs1;
  assign rf_rs2   = rs2;

  // Reads of the register being written this cycle see stale reg_ff data.
  assign w_hit1 = r_wr_en && (rs1 == r_rd);
  assign w_hit2 = r_wr_en && (rs2 == r_rd);

`ifdef RF_WB_BYPASS_EN
  // Forward the in-flight write per port; no stall needed.
  assign r1    = w_hit1 ? r_din : rf_r1;
  assign r2    = w_hit2 ? r_din : rf_r2;
  assign stall = 1'b0;
`else
  assign r1    = rf_r1;
  assign r2    = rf_r2;
  assign stall = w_hit1 | w_hit2;
`endif

endmodule : rf_wb_arb

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb + reg_ff: table of per-cycle stimulus with expected
// grants, a scoreboard queue for the write stage, and a register-file model.
module tb_rf_wb_arb;

  logic       clk;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [2:0] a_rd, b_rd, rs1, rs2;
  logic [7:0] a_data, b_data;
  logic [7:0] r1, r2;
  logic       stall;
  logic       rf_wr_en;
  logic [2:0] rf_rd, rf_rs1, rf_rs2;
  logic [7:0] rf_din, rf_r1, rf_r2;

  rf_wb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rs1(rs1), .rs2(rs2), .r1(r1), .r2(r2), .stall(stall),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_din(rf_din),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_r1(rf_r1), .rf_r2(rf_r2)
  );

  reg_ff u_rf (
    .clk(clk), .wr_en(rf_wr_en), .rd(rf_rd), .din(rf_din),
    .rs1(rf_rs1), .rs2(rf_rs2), .r1(rf_r1), .r2(rf_r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [2:0] ard;
    logic [7:0] adat;
    logic       bv;
    logic [2:0] brd;
    logic [7:0] bdat;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       ear;
    logic       ebr;
  } vec_t;

  typedef struct {
    logic       en;
    logic [2:0] rd;
    logic [7:0] data;
  } wr_t;

  wr_t        sb[$];
  vec_t       tbl[$];
  vec_t       tbl2[$];
  logic [7:0] mem_m[8];
  bit         known[8];
  int         n_checks;
  int         n_errors;

  function automatic vec_t mk(logic av, logic [2:0] ard, logic [7:0] adat,
                              logic bv, logic [2:0] brd, logic [7:0] bdat,
                              logic [2:0] s1, logic [2:0] s2, logic ear, logic ebr);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.bv = bv; v.brd = brd; v.bdat = bdat;
    v.rs1 = s1; v.rs2 = s2; v.ear = ear; v.ebr = ebr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at negedge, push expected write, commit model.
  task automatic step(input vec_t v);
    wr_t        cur;
    wr_t        nxt;
    logic       hit1, hit2;
    logic [7:0] e1, e2;
    bit         k1, k2;
    a_valid = v.av; a_rd = v.ard; a_data = v.adat;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bdat;
    rs1 = v.rs1; rs2 = v.rs2;
    @(negedge clk);
    chk("a_ready", 32'(a_ready), 32'(v.ear));
    chk("b_ready", 32'(b_ready), 32'(v.ebr));
    cur.en = 1'b0; cur.rd = 3'd0; cur.data = 8'd0;
    if (sb.size() > 0) cur = sb.pop_front();
    chk("rf_wr_en", 32'(rf_wr_en), 32'(cur.en));
    if (cur.en) begin
      chk("rf_rd", 32'(rf_rd), 32'(cur.rd));
      chk("rf_din", 32'(rf_din), 32'(cur.data));
    end
    hit1 = cur.en && (v.rs1 == cur.rd);
    hit2 = cur.en && (v.rs2 == cur.rd);
    e1 = mem_m[v.rs1]; k1 = known[v.rs1];
    e2 = mem_m[v.rs2]; k2 = known[v.rs2];
`ifdef RF_WB_BYPASS_EN
    chk("stall", 32'(stall), 32'd0);
    if (hit1) begin e1 = cur.data; k1 = 1'b1; end
    if (hit2) begin e2 = cur.data; k2 = 1'b1; end
`else
    chk("stall", 32'(stall), 32'(hit1 | hit2));
`endif
    if (k1) chk("r1", 32'(r1), 32'(e1));
    if (k2) chk("r2", 32'(r2), 32'(e2));
    nxt.en = 1'b0; nxt.rd = 3'd0; nxt.data = 8'd0;
    if (v.ear) begin
      nxt.en = 1'b1; nxt.rd = v.ard; nxt.data = v.adat;
    end else if (v.ebr) begin
      nxt.en = 1'b1; nxt.rd = v.brd; nxt.data = v.bdat;
    end
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    if (cur.en) begin
      mem_m[cur.rd] = cur.data;
      known[cur.rd] = 1'b1;
    end
  endtask

  task automatic apply_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_din", 32'(rf_din), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
  endtask

  initial begin
    wr_t pend;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    rs1 = '0; rs2 = '0;
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = 8'h00;
      known[i] = 1'b0;
    end

    //                av ard  adat   bv brd  bdat   rs1  rs2  ear ebr
    tbl.push_back(mk(1, 3'd1, 8'hAB, 1, 3'd2, 8'h03, 3'd0, 3'd0, 1, 0)); // tie from reset: A
    tbl.push_back(mk(1, 3'd3, 8'h5A, 1, 3'd2, 8'h03, 3'd0, 3'd0, 0, 1)); // tie again: B
    tbl.push_back(mk(1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 3'd1, 3'd5, 1, 0)); // A only
    tbl.push_back(mk(1, 3'd4, 8'h44, 0, 3'd0, 8'h00, 3'd2, 3'd1, 1, 0));
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd3, 3'd0, 0, 0));
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd3, 3'd4, 0, 0));
    tbl.push_back(mk(0, 3'd0, 8'h00, 1, 3'd0, 8'h0F, 3'd0, 3'd0, 0, 1)); // B grant
    tbl.push_back(mk(1, 3'd7, 8'h2D, 1, 3'd7, 8'h7C, 3'd0, 3'd0, 1, 0)); // same rd tie: A
    tbl.push_back(mk(0, 3'd0, 8'h00, 1, 3'd7, 8'h7C, 3'd7, 3'd0, 0, 1)); // B, hazard rs1
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd0, 3'd7, 0, 0)); // hazard rs2
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd7, 3'd7, 0, 0)); // R7 = 7C
    tbl.push_back(mk(1, 3'd1, 8'hA1, 1, 3'd2, 8'hB2, 3'd0, 3'd0, 1, 0)); // last B -> A
    tbl.push_back(mk(1, 3'd1, 8'hA3, 1, 3'd2, 8'hB2, 3'd0, 3'd0, 0, 1)); // last A -> B
    tbl.push_back(mk(1, 3'd1, 8'hA3, 0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 0));
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0));
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd1, 3'd2, 0, 0));
    tbl.push_back(mk(1, 3'd5, 8'h3F, 0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 0)); // write R5
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd5, 3'd4, 0, 0)); // hazard window
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd5, 3'd4, 0, 0));
    tbl.push_back(mk(0, 3'd0, 8'h00, 1, 3'd6, 8'h11, 3'd0, 3'd0, 0, 1)); // R6 = 11
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0));
    tbl.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd6, 3'd0, 0, 0));
    tbl.push_back(mk(1, 3'd6, 8'h6B, 0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 0)); // write lost to reset

    // After mid-write reset: last winner is B again, so A wins the tie.
    tbl2.push_back(mk(1, 3'd6, 8'h6B, 1, 3'd3, 8'h33, 3'd6, 3'd3, 1, 0));
    tbl2.push_back(mk(0, 3'd0, 8'h00, 1, 3'd3, 8'h33, 3'd0, 3'd0, 0, 1));
    tbl2.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0));
    tbl2.push_back(mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd6, 3'd3, 0, 0));

    apply_reset();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset in the middle of the write-stage cycle for R6.
    a_valid = 1'b0; b_valid = 1'b0;
    #2;
    pend.en = 1'b0; pend.rd = 3'd0; pend.data = 8'd0;
    if (sb.size() > 0) pend = sb.pop_front();
    chk("midrst_pre_wr_en", 32'(rf_wr_en), 32'(pend.en));
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("midrst_rd", 32'(rf_rd), 32'd0);
    chk("midrst_din", 32'(rf_din), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < tbl2.size(); i++) step(tbl2[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rf_wb_arb
